// File: rtl/pmem_arbiter.sv
// Purpose: arbitrates one physical memory port between I-cache fills and D-cache fills/writebacks.
// Latency: request sampled in IDLE at edge N drives the pmem command from cycle N+1 until pmem_resp.
// Backpressure: requesters hold their level request until their resp pulse; the loser simply waits.
//
// Ports:
//   clk, rst                       sole clock; synchronous active-high reset
//   icache_pmem_read/address       I-cache fill request (level) and line address
//   icache_pmem_rdata/resp         fill data and one-cycle completion pulse to the I-cache
//   dcache_pmem_read/write/address D-cache fill / writeback request (level) and line address
//   dcache_pmem_wdata              D-cache writeback line
//   dcache_pmem_rdata/resp         fill data and one-cycle completion pulse to the D-cache
//   pmem_read/write/address/wdata  command to physical memory, driven only from latched registers
//   pmem_rdata/resp                physical memory read data and completion pulse
module pmem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  icache_pmem_read,
  input  logic [ADDR_WIDTH-1:0] icache_pmem_address,
  output logic [LINE_WIDTH-1:0] icache_pmem_rdata,
  output logic                  icache_pmem_resp,
  input  logic                  dcache_pmem_read,
  input  logic                  dcache_pmem_write,
  input  logic [ADDR_WIDTH-1:0] dcache_pmem_address,
  input  logic [LINE_WIDTH-1:0] dcache_pmem_wdata,
  output logic [LINE_WIDTH-1:0] dcache_pmem_rdata,
  output logic                  dcache_pmem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t                  state;
  logic                    last_grant_d;   // 1: D-cache was served most recently
  logic                    cmd_read;
  logic                    cmd_write;
  logic [ADDR_WIDTH-1:0]   cmd_address;
  logic [LINE_WIDTH-1:0]   cmd_wdata;

  logic i_req;
  logic d_req;
  logic grant_i;
  logic grant_d;

  assign i_req   = icache_pmem_read;
  assign d_req   = dcache_pmem_read | dcache_pmem_write;
  // On a tie the side that was not served last wins.
  assign grant_i = i_req & (~d_req | last_grant_d);
  assign grant_d = d_req & ~grant_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant_d <= 1'b1;
      cmd_read     <= 1'b0;
      cmd_write    <= 1'b0;
      cmd_address  <= '0;
      cmd_wdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_i) begin
            state        <= SERVE_I;
            cmd_read     <= 1'b1;
            cmd_write    <= 1'b0;
            cmd_address  <= icache_pmem_address;
            last_grant_d <= 1'b0;
          end else if (grant_d) begin
            state        <= SERVE_D;
            // read+write together is treated as a writeback
            cmd_read     <= ~dcache_pmem_write;
            cmd_write    <= dcache_pmem_write;
            cmd_address  <= dcache_pmem_address;
            if (dcache_pmem_write) begin
              cmd_wdata <= dcache_pmem_wdata;
            end
            last_grant_d <= 1'b1;
          end
        end
        SERVE_I, SERVE_D: begin
          // Dropping the command here keeps it low through RELEASE.
          if (pmem_resp) begin
            state     <= RELEASE;
            cmd_read  <= 1'b0;
            cmd_write <= 1'b0;
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign pmem_read    = cmd_read;
  assign pmem_write   = cmd_write;
  assign pmem_address = cmd_address;
  assign pmem_wdata   = cmd_wdata;

  assign icache_pmem_rdata = pmem_rdata;
  assign dcache_pmem_rdata = pmem_rdata;

  // A reset cycle aborts the transaction, so no completion is forwarded during it.
  assign icache_pmem_resp = ~rst & (state == SERVE_I) & pmem_resp;
  assign dcache_pmem_resp = ~rst & (state == SERVE_D) & pmem_resp;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Purpose: self-checking bench for pmem_arbiter: directed scenarios plus randomized cache/memory agents.
// Latency: checks outputs at every falling edge against a transaction-level reference model.
// Backpressure: cache agents hold requests until their resp; memory agent answers after a random delay.
module tb_pmem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         icache_pmem_read;
  logic [15:0]  icache_pmem_address;
  logic [127:0] icache_pmem_rdata;
  logic         icache_pmem_resp;
  logic         dcache_pmem_read;
  logic         dcache_pmem_write;
  logic [15:0]  dcache_pmem_address;
  logic [127:0] dcache_pmem_wdata;
  logic [127:0] dcache_pmem_rdata;
  logic         dcache_pmem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  pmem_arbiter #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .icache_pmem_read    (icache_pmem_read),
    .icache_pmem_address (icache_pmem_address),
    .icache_pmem_rdata   (icache_pmem_rdata),
    .icache_pmem_resp    (icache_pmem_resp),
    .dcache_pmem_read    (dcache_pmem_read),
    .dcache_pmem_write   (dcache_pmem_write),
    .dcache_pmem_address (dcache_pmem_address),
    .dcache_pmem_wdata   (dcache_pmem_wdata),
    .dcache_pmem_rdata   (dcache_pmem_rdata),
    .dcache_pmem_resp    (dcache_pmem_resp),
    .pmem_read           (pmem_read),
    .pmem_write          (pmem_write),
    .pmem_address        (pmem_address),
    .pmem_wdata          (pmem_wdata),
    .pmem_rdata          (pmem_rdata),
    .pmem_resp           (pmem_resp)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model (transaction level) ----------------
  // owner: 0 nobody, 1 I-cache, 2 D-cache; gap marks the one-cycle pause after a completion.
  int           m_owner  = 0;
  bit           m_gap    = 0;
  bit           m_last_i = 0;
  bit           m_rd     = 0;
  bit           m_wr     = 0;
  logic [15:0]  m_addr   = '0;
  logic [127:0] m_wdata  = '0;
  bit           m_valid  = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_owner = 0; m_gap = 0; m_last_i = 0;
      m_rd = 0; m_wr = 0; m_addr = '0; m_wdata = '0;
      m_valid = 1;
    end else if (m_owner != 0) begin
      if (pmem_resp) begin
        m_owner = 0; m_gap = 1; m_rd = 0; m_wr = 0;
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else begin
      bit want_i, want_d;
      want_i = icache_pmem_read;
      want_d = dcache_pmem_read || dcache_pmem_write;
      if (want_i && (!want_d || !m_last_i)) begin
        m_owner = 1; m_rd = 1; m_wr = 0; m_addr = icache_pmem_address; m_last_i = 1;
      end else if (want_d) begin
        m_owner = 2; m_wr = dcache_pmem_write; m_rd = !dcache_pmem_write;
        m_addr = dcache_pmem_address; m_last_i = 0;
        if (dcache_pmem_write) m_wdata = dcache_pmem_wdata;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("mdl_pmem_read",  128'(pmem_read),  128'(m_rd));
      chk("mdl_pmem_write", 128'(pmem_write), 128'(m_wr));
      chk("mdl_pmem_addr",  128'(pmem_address), 128'(m_addr));
      chk("mdl_pmem_wdata", pmem_wdata, m_wdata);
      chk("mdl_i_resp", 128'(icache_pmem_resp), 128'(!rst && m_owner == 1 && pmem_resp));
      chk("mdl_d_resp", 128'(dcache_pmem_resp), 128'(!rst && m_owner == 2 && pmem_resp));
      chk("mdl_i_rdata", icache_pmem_rdata, pmem_rdata);
      chk("mdl_d_rdata", dcache_pmem_rdata, pmem_rdata);
    end
  end

  // resp observed by each cache in the cycle just ended
  bit i_got = 0;
  bit d_got = 0;
  always @(negedge clk) begin
    i_got = icache_pmem_resp;
    d_got = dcache_pmem_resp;
  end

  initial begin
    bit i_pend, d_pend;
    int mcnt;
    rst = 1'b1;
    icache_pmem_read = 0; icache_pmem_address = '0;
    dcache_pmem_read = 0; dcache_pmem_write = 0;
    dcache_pmem_address = '0; dcache_pmem_wdata = '0;
    pmem_rdata = '0; pmem_resp = 0;

    // reset values
    tick(); tick();
    @(negedge clk);
    chk("rst_read",  128'(pmem_read), 128'(0));
    chk("rst_write", 128'(pmem_write), 128'(0));
    chk("rst_addr",  128'(pmem_address), 128'(0));
    chk("rst_wdata", pmem_wdata, 128'(0));
    chk("rst_iresp", 128'(icache_pmem_resp), 128'(0));
    chk("rst_dresp", 128'(dcache_pmem_resp), 128'(0));

    // lone I read of 0x1230, memory answers in the third serve cycle
    tick(); rst = 0; icache_pmem_read = 1; icache_pmem_address = 16'h1230;
    tick();
    @(negedge clk);
    chk("i_alone_read", 128'(pmem_read), 128'(1));
    chk("i_alone_addr", 128'(pmem_address), 128'h1230);
    chk("i_alone_write", 128'(pmem_write), 128'(0));
    tick(); tick(); pmem_resp = 1; pmem_rdata = {4{32'hDEAD_BEEF}};
    @(negedge clk);
    chk("i_alone_resp", 128'(icache_pmem_resp), 128'(1));
    chk("i_alone_rdata", icache_pmem_rdata, {4{32'hDEAD_BEEF}});
    chk("i_alone_dresp", 128'(dcache_pmem_resp), 128'(0));
    tick(); pmem_resp = 0; icache_pmem_read = 0;
    @(negedge clk);
    chk("release_read", 128'(pmem_read), 128'(0));
    chk("release_iresp", 128'(icache_pmem_resp), 128'(0));

    // tie from reset: I first, then D writeback, then I again
    tick(); rst = 1;
    tick(); rst = 0;
    icache_pmem_read = 1; icache_pmem_address = 16'h0040;
    dcache_pmem_write = 1; dcache_pmem_address = 16'h0080; dcache_pmem_wdata = {16{8'hA5}};
    tick();
    @(negedge clk);
    chk("tie1_read", 128'(pmem_read), 128'(1));
    chk("tie1_addr", 128'(pmem_address), 128'h0040);
    tick(); pmem_resp = 1;
    @(negedge clk);
    chk("tie1_iresp", 128'(icache_pmem_resp), 128'(1));
    chk("tie1_dresp", 128'(dcache_pmem_resp), 128'(0));
    tick(); pmem_resp = 0; icache_pmem_read = 0;
    tick();
    tick(); icache_pmem_read = 1;
    @(negedge clk);
    chk("tie_d_write", 128'(pmem_write), 128'(1));
    chk("tie_d_read",  128'(pmem_read), 128'(0));
    chk("tie_d_addr",  128'(pmem_address), 128'h0080);
    chk("tie_d_wdata", pmem_wdata, {16{8'hA5}});
    tick(); pmem_resp = 1;
    @(negedge clk);
    chk("tie_d_dresp", 128'(dcache_pmem_resp), 128'(1));
    chk("tie_d_iresp", 128'(icache_pmem_resp), 128'(0));
    tick(); pmem_resp = 0;
    tick();
    tick();
    @(negedge clk);
    chk("tie2_read", 128'(pmem_read), 128'(1));
    chk("tie2_addr", 128'(pmem_address), 128'h0040);
    tick(); pmem_resp = 1;
    tick(); pmem_resp = 0; icache_pmem_read = 0; dcache_pmem_write = 0;
    tick();

    // D address changes mid-service
    dcache_pmem_read = 1; dcache_pmem_address = 16'h0100;
    tick();
    @(negedge clk);
    chk("hold_addr0", 128'(pmem_address), 128'h0100);
    tick(); dcache_pmem_address = 16'h0200;
    @(negedge clk);
    chk("hold_addr1", 128'(pmem_address), 128'h0100);
    tick(); pmem_resp = 1;
    @(negedge clk);
    chk("hold_addr2", 128'(pmem_address), 128'h0100);
    chk("hold_dresp", 128'(dcache_pmem_resp), 128'(1));
    tick(); pmem_resp = 0; dcache_pmem_read = 0;
    tick();

    // read and write together behave as a write
    dcache_pmem_read = 1; dcache_pmem_write = 1; dcache_pmem_address = 16'h0400;
    dcache_pmem_wdata = {4{32'h0123_4567}};
    tick();
    @(negedge clk);
    chk("rw_write", 128'(pmem_write), 128'(1));
    chk("rw_read",  128'(pmem_read), 128'(0));
    tick(); pmem_resp = 1;
    tick(); pmem_resp = 0; dcache_pmem_read = 0; dcache_pmem_write = 0;
    tick();

    // reset in the middle of a D service, with a resp arriving in the reset cycle and after
    dcache_pmem_read = 1; dcache_pmem_address = 16'h0500;
    tick();
    @(negedge clk);
    chk("abort_pre_read", 128'(pmem_read), 128'(1));
    tick(); rst = 1; dcache_pmem_read = 0; pmem_resp = 1;
    @(negedge clk);
    chk("abort_rst_dresp", 128'(dcache_pmem_resp), 128'(0));
    tick(); rst = 0;
    @(negedge clk);
    chk("abort_read",  128'(pmem_read), 128'(0));
    chk("abort_write", 128'(pmem_write), 128'(0));
    chk("abort_addr",  128'(pmem_address), 128'(0));
    chk("abort_wdata", pmem_wdata, 128'(0));
    chk("stray_dresp", 128'(dcache_pmem_resp), 128'(0));
    chk("stray_iresp", 128'(icache_pmem_resp), 128'(0));
    tick(); pmem_resp = 0;
    @(negedge clk);
    chk("stray_no_grant", 128'(pmem_read | pmem_write), 128'(0));

    // randomized traffic
    i_pend = 0; d_pend = 0; mcnt = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tick();
      rst = ($urandom_range(0, 299) == 0);
      pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
      pmem_resp = 0;
      if (pmem_read || pmem_write) begin
        if (mcnt == 0) begin
          pmem_resp = 1;
          mcnt = $urandom_range(0, 4);
        end else begin
          mcnt--;
        end
      end else if ($urandom_range(0, 19) == 0) begin
        pmem_resp = 1;
      end

      if (i_pend && i_got) begin
        i_pend = 0; icache_pmem_read = 0;
      end else if (!i_pend && $urandom_range(0, 2) == 0) begin
        i_pend = 1; icache_pmem_read = 1; icache_pmem_address = 16'($urandom);
      end

      if (d_pend && d_got) begin
        d_pend = 0; dcache_pmem_read = 0; dcache_pmem_write = 0;
      end else if (!d_pend && $urandom_range(0, 2) == 0) begin
        int k;
        k = $urandom_range(0, 2);
        d_pend = 1;
        dcache_pmem_read  = (k != 1);
        dcache_pmem_write = (k != 0);
        dcache_pmem_address = 16'($urandom);
        dcache_pmem_wdata = {$urandom, $urandom, $urandom, $urandom};
      end else if (d_pend && $urandom_range(0, 9) == 0) begin
        dcache_pmem_address = 16'($urandom);
        dcache_pmem_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
    end

    tick();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
